// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: Op encoding and FSM state codes.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO pair, updated one edge after a FIX result or an MTHI/MTLO write.
// The FIX result has priority; the caller already blocks MT writes while busy, so no stall is needed here.
module hilo_reg
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fix_we,
  input  logic [WIDTH-1:0] fix_hi,
  input  logic [WIDTH-1:0] fix_lo,
  input  logic             mt_we_hi,
  input  logic             mt_we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fix_we) begin
      hi_d = fix_hi;
      lo_d = fix_lo;
    end else begin
      if (mt_we_hi) hi_d = wd;
      if (mt_we_lo) lo_d = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes, one bit per cycle, with a sign-fix cycle.
// Done pulses WIDTH+2 edges after Start is accepted; Busy covers CALC and FIX so the pipeline stalls.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             WEHI,
  input  logic             WELO,
  input  logic [WIDTH-1:0] WD,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sgn_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   m_sum;
  logic [WIDTH:0]   d_shift;
  logic             d_borrow;
  logic [WIDTH-1:0] d_rem;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             fix_we, mt_en;

  always_comb begin
    sgn_op = 1'b0;
    div_op = 1'b0;
    case (Op)
      OP_MULT:  sgn_op = 1'b1;
      OP_MULTU: sgn_op = 1'b0;
      OP_DIV:   begin sgn_op = 1'b1; div_op = 1'b1; end
      OP_DIVU:  div_op = 1'b1;
    endcase
    a_neg = sgn_op & SrcA[WIDTH-1];
    b_neg = sgn_op & SrcB[WIDTH-1];
    a_mag = a_neg ? -SrcA : SrcA;
    b_mag = b_neg ? -SrcB : SrcB;
  end

  // Multiply: {acc, shf} is the product register with the multiplier in the low half.
  // Divide: shf holds the dividend bits shifting out and the quotient bits shifting in.
  always_comb begin
    m_sum    = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : '0);
    d_shift  = {acc_q, shf_q[WIDTH-1]};
    d_borrow = d_shift < {1'b0, opnd_q};
    d_rem    = WIDTH'(d_shift - {1'b0, opnd_q});
  end

  // A zero divisor never borrows, so acc ends holding |SrcA| and the sign fix restores SrcA.
  always_comb begin
    prod   = {acc_q, shf_q};
    prod_s = neg_lo_q ? -prod : prod;
    if (is_div_q) begin
      fix_hi = neg_hi_q ? -acc_q : acc_q;
      fix_lo = bzero_q ? '1 : (neg_lo_q ? -shf_q : shf_q);
    end else begin
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
      fix_lo = prod_s[WIDTH-1:0];
    end
    fix_we = (state_q == ST_FIX);
    mt_en  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shf_d    = shf_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          acc_d    = '0;
          is_div_d = div_op;
          opnd_d   = div_op ? b_mag : a_mag;
          shf_d    = div_op ? a_mag : b_mag;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          bzero_d  = (SrcB == '0);
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          acc_d = d_borrow ? d_shift[WIDTH-1:0] : d_rem;
          shf_d = {shf_q[WIDTH-2:0], ~d_borrow};
        end else begin
          acc_d = m_sum[WIDTH:1];
          shf_d = {m_sum[0], shf_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shf_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .fix_we   (fix_we),
    .fix_hi   (fix_hi),
    .fix_lo   (fix_lo),
    .mt_we_hi (WEHI & mt_en),
    .mt_we_lo (WELO & mt_en),
    .wd       (WD),
    .hi       (HI),
    .lo       (LO)
  );

  assign Busy = busy_q;
  assign Done = done_q;

endmodule
